// File: rtl/lsu_bus_ctrl.sv
// Load/store unit bus controller: one request at a time over a req/ack data bus,
// with byte-lane store formatting, load alignment/extension and misalignment traps.

module lsu_lane #(
    parameter int LANE = 0
) (
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic        strb,
    output logic [7:0]  wbyte
);
    localparam logic [1:0] IDX = 2'(LANE);

    always_comb begin
        strb  = 1'b0;
        wbyte = wdata[8*LANE +: 8];
        case (size)
            2'b00: begin
                strb  = (off == IDX);
                wbyte = wdata[7:0];
            end
            2'b01: begin
                strb  = (off[1] == IDX[1]);
                wbyte = IDX[0] ? wdata[15:8] : wdata[7:0];
            end
            2'b10:   strb = 1'b1;
            default: strb = 1'b0;
        endcase
        if (!we) strb = 1'b0;
    end
endmodule

module lsu_bus_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_ale,
    output logic        resp_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    localparam int          NUM_LANES = 4;
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT) - 32'd1;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    state_t                         state, state_nxt;
    lsu_req_t                       req_q;
    logic [31:0]                    tmo_cnt;
    logic [31:0]                    rdata_q;
    logic                           ale_q, err_q;
    logic                           misaligned, timeout_hit;
    logic [31:0]                    load_fmt;
    logic [7:0]                     ld_byte;
    logic [15:0]                    ld_half;
    logic [NUM_LANES-1:0]           lane_strb;
    logic [NUM_LANES-1:0][7:0]      lane_wbyte;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            2'b11:   misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    // Timeout fires in the BUS cycle that would bring the count to TIMEOUT.
    assign timeout_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

    // Store formatting is per byte lane, driven from the latched request.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lsu_lane #(.LANE(i)) u_lane (
            .we    (req_q.we),
            .size  (req_q.size),
            .off   (req_q.addr[1:0]),
            .wdata (req_q.wdata),
            .strb  (lane_strb[i]),
            .wbyte (lane_wbyte[i])
        );
    end

    always_comb begin
        ld_byte  = bus_rdata[{req_q.addr[1:0], 3'b000} +: 8];
        ld_half  = req_q.addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        load_fmt = bus_rdata;
        case (req_q.size)
            2'b00:   load_fmt = {{24{ld_byte[7] & ~req_q.uns}}, ld_byte};
            2'b01:   load_fmt = {{16{ld_half[15] & ~req_q.uns}}, ld_half};
            default: load_fmt = bus_rdata;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = misaligned ? RESP : BUS;
            BUS:     if (bus_ack || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        bus_req    = (state == BUS);
        resp_valid = (state == RESP);
        bus_we     = bus_req & req_q.we;
        bus_addr   = bus_req ? {req_q.addr[31:2], 2'b00} : 32'd0;
        bus_wstrb  = bus_req ? lane_strb : 4'd0;
        bus_wdata  = bus_req ? lane_wbyte : 32'd0;
        resp_rdata = resp_valid ? rdata_q : 32'd0;
        resp_ale   = resp_valid & ale_q;
        resp_err   = resp_valid & err_q;
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            req_q   <= '0;
            tmo_cnt <= '0;
            rdata_q <= '0;
            ale_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    req_q   <= '{we: req_we, size: req_size, uns: req_unsigned,
                                 addr: req_addr, wdata: req_wdata};
                    tmo_cnt <= '0;
                    rdata_q <= '0;
                    ale_q   <= misaligned;
                    err_q   <= 1'b0;
                end
                BUS: begin
                    if (bus_ack) begin
                        rdata_q <= req_q.we ? 32'd0 : load_fmt;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                        if (timeout_hit) err_q <= 1'b1;
                    end
                end
                default: begin
                    ale_q <= 1'b0;
                    err_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Bench for lsu_bus_ctrl: directed scenarios plus randomized transactions
// checked against a specification-level model of formatting, latency and timeout.

module tb_lsu_bus_ctrl;
    localparam int TO = 4;

    logic        cpu_clk, cpu_rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ale, resp_err;
    logic [31:0] resp_rdata;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;

    int checks = 0;
    int errors = 0;

    lsu_bus_ctrl #(.TIMEOUT(TO)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_ale(resp_ale), .resp_err(resp_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    function automatic logic misal(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'b11) return 1'b1;
        if (size == 2'b01) return addr[0];
        if (size == 2'b10) return addr[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] size, input logic uns,
                                             input logic [1:0] o, input logic [31:0] rd);
        logic [31:0] v;
        v = rd;
        if (size == 2'b00) begin
            v = (rd >> (8 * o)) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = (rd >> (16 * o[1])) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] exp_strb(input logic we, input logic [1:0] size,
                                            input logic [1:0] o);
        if (!we) return 4'b0000;
        if (size == 2'b00) return 4'(1 << o);
        if (size == 2'b01) return o[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] w);
        if (size == 2'b00) return {4{w[7:0]}};
        if (size == 2'b01) return {2{w[15:0]}};
        return w;
    endfunction

    // ack_cycle: BUS cycle (1-based) in which bus_ack is raised; outside 1..TO means timeout.
    task automatic do_txn(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int ack_cycle, input string name);
        logic        mis, exp_err;
        int          nb;
        logic [31:0] exp_rd, exp_wd, tmp;
        logic [3:0]  ew;
        mis     = misal(size, addr);
        exp_err = !(ack_cycle >= 1 && ack_cycle <= TO);
        nb      = exp_err ? TO : ack_cycle;
        exp_rd  = (we || exp_err) ? 32'd0 : exp_load(size, uns, addr[1:0], rdata);
        ew      = exp_strb(we, size, addr[1:0]);
        exp_wd  = exp_wdata(size, wdata);

        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_ready: req_ready=%b expected 1", name, req_ready);
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge cpu_clk); #1;
        req_valid = 1'b0;
        tmp = $urandom; req_addr = tmp;
        tmp = $urandom; req_wdata = tmp;
        req_we = ~we;

        if (mis) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_ale !== 1'b1 || resp_err !== 1'b0 ||
                resp_rdata !== 32'd0 || bus_req !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s ale_resp: valid=%b ale=%b err=%b rdata=%h bus_req=%b expected 1 1 0 0 0",
                         name, resp_valid, resp_ale, resp_err, resp_rdata, bus_req);
            end
        end else begin
            for (int k = 1; k <= nb; k++) begin
                checks++;
                if (bus_req !== 1'b1 || bus_we !== we || bus_addr !== {addr[31:2], 2'b00} ||
                    bus_wstrb !== ew || (we && bus_wdata !== exp_wd) ||
                    resp_valid !== 1'b0 || req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s bus_k%0d: req=%b we=%b addr=%h strb=%b wdata=%h expected 1 %b %h %b %h",
                             name, k, bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
                             we, {addr[31:2], 2'b00}, ew, exp_wd);
                end
                tmp = $urandom;
                bus_rdata = (k == ack_cycle) ? rdata : tmp;
                bus_ack   = (k == ack_cycle);
                @(posedge cpu_clk); #1;
                bus_ack = 1'b0;
            end
            // A late ack lands in the response cycle and must be ignored.
            if (ack_cycle == nb + 1) begin
                bus_ack = 1'b1; bus_rdata = rdata;
            end
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== exp_rd || resp_ale !== 1'b0 ||
                resp_err !== exp_err || bus_req !== 1'b0) begin
                errors++;
                $display("FAIL %s resp: valid=%b rdata=%h ale=%b err=%b bus_req=%b expected 1 %h 0 %b 0",
                         name, resp_valid, resp_rdata, resp_ale, resp_err, bus_req, exp_rd, exp_err);
            end
        end
        @(posedge cpu_clk); #1;
        bus_ack = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_ale !== 1'b0 ||
            resp_err !== 1'b0 || req_ready !== 1'b1 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL %s after_resp: valid=%b rdata=%h ale=%b err=%b ready=%b bus_req=%b expected 0 0 0 0 1 0",
                     name, resp_valid, resp_rdata, resp_ale, resp_err, req_ready, bus_req);
        end
    endtask

    task automatic test_reset;
        cpu_rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        bus_ack = 1'b0; bus_rdata = 32'd0;
        #2;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 ||
            resp_ale !== 1'b0 || resp_err !== 1'b0 || bus_req !== 1'b0 || bus_we !== 1'b0 ||
            bus_addr !== 32'd0 || bus_wstrb !== 4'd0 || bus_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b valid=%b bus_req=%b addr=%h strb=%b expected 1 0 0 0 0",
                     req_ready, resp_valid, bus_req, bus_addr, bus_wstrb);
        end
        @(posedge cpu_clk); @(posedge cpu_clk); #1;
        cpu_rst = 1'b0;
        @(posedge cpu_clk); #1;
    endtask

    task automatic test_loads;
        do_txn(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 3, "ld_byte_signed");
        do_txn(1'b0, 2'b01, 1'b1, 32'h0000_1002, 32'h0, 32'h80FF_1234, 3, "ld_half_unsigned");
        do_txn(1'b0, 2'b01, 1'b0, 32'h0000_1000, 32'h0, 32'h1234_9ABC, 1, "ld_half_signed");
        do_txn(1'b0, 2'b10, 1'b0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 1, "ld_word");
    endtask

    task automatic test_stores;
        do_txn(1'b1, 2'b00, 1'b0, 32'h0000_2001, 32'h0000_00AB, 32'h5555_5555, 3, "st_byte");
        do_txn(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_1234, 32'h5555_5555, 2, "st_half");
        do_txn(1'b1, 2'b10, 1'b0, 32'h0000_2008, 32'hCAFE_F00D, 32'h5555_5555, 1, "st_word");
    endtask

    task automatic test_misaligned;
        do_txn(1'b0, 2'b10, 1'b0, 32'h0000_1002, 32'h0, 32'h0, 1, "mis_word");
        do_txn(1'b0, 2'b11, 1'b0, 32'h0000_1000, 32'h0, 32'h0, 1, "mis_size11");
        do_txn(1'b1, 2'b01, 1'b0, 32'h0000_1003, 32'h1234, 32'h0, 1, "mis_half_store");
    endtask

    task automatic test_timeout;
        do_txn(1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0, 32'h1111_2222, 0, "timeout");
        do_txn(1'b0, 2'b10, 1'b0, 32'h0000_3004, 32'h0, 32'h3333_4444, TO, "ack_last_cycle");
        do_txn(1'b1, 2'b10, 1'b0, 32'h0000_3008, 32'h7777_8888, 32'h0, TO + 1, "timeout_late_ack");
    endtask

    task automatic test_reset_mid;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_4000;
        @(posedge cpu_clk); #1;
        req_valid = 1'b0;
        @(posedge cpu_clk); #1;
        checks++;
        if (bus_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_busy: bus_req=%b expected 1", bus_req);
        end
        cpu_rst = 1'b1;
        #1;
        checks++;
        if (bus_req !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1 || bus_addr !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_drop: bus_req=%b valid=%b ready=%b addr=%h expected 0 0 1 0",
                     bus_req, resp_valid, req_ready, bus_addr);
        end
        @(posedge cpu_clk); #1;
        cpu_rst = 1'b0;
        @(posedge cpu_clk); #1;
        do_txn(1'b0, 2'b00, 1'b1, 32'h0000_4001, 32'h0, 32'hA1B2_C3D4, 2, "rst_mid_next");
    endtask

    task automatic test_back_to_back;
        logic [31:0] a[3], d[3], tmp;
        for (int i = 0; i < 3; i++) begin
            tmp = $urandom; a[i] = tmp & 32'hFFFF_FFFC;
            tmp = $urandom; d[i] = tmp;
        end
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = a[0];
        for (int i = 0; i < 3; i++) begin
            @(posedge cpu_clk); #1;
            checks++;
            if (bus_req !== 1'b1 || bus_addr !== a[i]) begin
                errors++;
                $display("FAIL b2b_bus%0d: bus_req=%b addr=%h expected 1 %h", i, bus_req, bus_addr, a[i]);
            end
            bus_ack = 1'b1; bus_rdata = d[i];
            if (i < 2) req_addr = a[i+1];
            else       req_valid = 1'b0;
            @(posedge cpu_clk); #1;
            bus_ack = 1'b0;
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== d[i] || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_resp%0d: valid=%b rdata=%h ready=%b expected 1 %h 0",
                         i, resp_valid, resp_rdata, req_ready, d[i]);
            end
            @(posedge cpu_clk); #1;
            checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1 || bus_req !== 1'b0) begin
                errors++;
                $display("FAIL b2b_idle%0d: valid=%b ready=%b bus_req=%b expected 0 1 0",
                         i, resp_valid, req_ready, bus_req);
            end
        end
        @(posedge cpu_clk); #1;
        checks++;
        if (bus_req !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_extra: bus_req=%b valid=%b expected 0 0", bus_req, resp_valid);
        end
    endtask

    task automatic test_random;
        logic [31:0] a, w, r;
        logic [1:0]  sz;
        logic        we, uns;
        int          ac;
        for (int n = 0; n < 40; n++) begin
            a  = $urandom;
            w  = $urandom;
            r  = $urandom;
            sz = 2'($urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            ac = $urandom_range(1, TO + 1);
            do_txn(we, sz, uns, a, w, r, ac, "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_loads;
        test_stores;
        test_misaligned;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
